// File: rtl/vga_timing_pkg.sv
// XGA 1024x768@60 raster constants shared by the timing generator and its
// axis counters, plus a small window-compare helper.
package vga_timing_pkg;

  localparam int CNT_W = 16;

  // Horizontal timing, in pixels.
  localparam int H_ACTIVE = 1024;
  localparam int H_FP     = 24;
  localparam int H_SYNC   = 136;
  localparam int H_BP     = 160;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;  // 1344

  // Vertical timing, in lines.
  localparam int V_ACTIVE = 768;
  localparam int V_FP     = 3;
  localparam int V_SYNC   = 6;
  localparam int V_BP     = 29;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;  // 806

  // Inclusive sync windows.
  localparam int H_SYNC_START = H_ACTIVE + H_FP;              // 1048
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;    // 1183
  localparam int V_SYNC_START = V_ACTIVE + V_FP;              // 771
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;    // 776

  // XGA uses negative sync on both axes.
  localparam logic HSYNC_POL = 1'b0;
  localparam logic VSYNC_POL = 1'b0;

  // Unsigned inclusive range test used for the sync windows.
  function automatic logic in_window(input logic [CNT_W-1:0] value,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (value >= lo) && (value <= hi);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter with registered sync and
// blank strobes. Strobes are computed from the value the counter is about
// to take, so count, sync and blank always describe the same position.
// wrap is combinational and flags that the current position is the last.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int   ACTIVE = 1024,
  parameter int   FP     = 24,
  parameter int   SYNC   = 136,
  parameter int   BP     = 160,
  parameter logic POL    = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        step,
  output logic [15:0] count,
  output logic        sync,
  output logic        blank,
  output logic        wrap
);

  localparam logic [15:0] LAST       = 16'(ACTIVE + FP + SYNC + BP - 1);
  localparam logic [15:0] ACT_END    = 16'(ACTIVE);
  localparam logic [15:0] SYNC_START = 16'(ACTIVE + FP);
  localparam logic [15:0] SYNC_END   = 16'(ACTIVE + FP + SYNC - 1);

  logic [15:0] count_next;

  assign wrap = (count == LAST);

  // Next position: advance on step, returning to 0 after the last position.
  always_comb begin
    count_next = count;
    if (step) begin
      count_next = wrap ? 16'd0 : count + 16'd1;
    end
  end

  // Position and strobe registers; everything holds while step is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 16'd0;
      sync  <= ~POL;
      blank <= 1'b0;
    end else if (step) begin
      count <= count_next;
      sync  <= in_window(count_next, SYNC_START, SYNC_END) ? POL : ~POL;
      blank <= (count_next >= ACT_END);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing source (XGA defaults). Outputs are all
// registered and aligned to the same pixel. There is no handshake: the
// downstream stages consume every cycle and en is the only flow control;
// while en is low every output holds and frame_start stays low.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE  = vga_timing_pkg::H_ACTIVE,
  parameter int   H_FP      = vga_timing_pkg::H_FP,
  parameter int   H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int   H_BP      = vga_timing_pkg::H_BP,
  parameter int   V_ACTIVE  = vga_timing_pkg::V_ACTIVE,
  parameter int   V_FP      = vga_timing_pkg::V_FP,
  parameter int   V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int   V_BP      = vga_timing_pkg::V_BP,
  parameter logic HSYNC_POL = vga_timing_pkg::HSYNC_POL,
  parameter logic VSYNC_POL = vga_timing_pkg::VSYNC_POL
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [15:0] hcount_out,
  output logic [15:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic        frame_start
);

  logic h_wrap;
  logic v_wrap;
  logic v_step;

  // The vertical axis moves only when the line finishes.
  assign v_step = en & h_wrap;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (HSYNC_POL)
  ) u_h_axis (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (en),
    .count (hcount_out),
    .sync  (hsync_out),
    .blank (hblnk_out),
    .wrap  (h_wrap)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (VSYNC_POL)
  ) u_v_axis (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (v_step),
    .count (vcount_out),
    .sync  (vsync_out),
    .blank (vblnk_out),
    .wrap  (v_wrap)
  );

  // Pulse in the cycle the counters show (0,0) after leaving the last pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= en & h_wrap & v_wrap;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size XGA instance plus a tiny-raster
// instance with inverted sync polarity, both checked every cycle against a
// frame-position model (pixel index p -> h = p % H_TOTAL, v = p / H_TOTAL).
module tb_vga_timing_gen;

  // Tiny raster for instance B: 16 x 10, hsync 10..12, vsync 7..8.
  localparam int BHA = 8, BHF = 2, BHS = 3, BHB = 3;
  localparam int BVA = 6, BVF = 1, BVS = 2, BVB = 1;
  localparam int FRAME_A = 1344 * 806;
  localparam int FRAME_B = 16 * 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] hcount_a, vcount_a, hcount_b, vcount_b;
  logic hsync_a, vsync_a, hblnk_a, vblnk_a, fs_a;
  logic hsync_b, vsync_b, hblnk_b, vblnk_b, fs_b;

  vga_timing_gen dut_a (
    .clk(clk), .rst_n(rst_n), .en(en),
    .hcount_out(hcount_a), .vcount_out(vcount_a),
    .hsync_out(hsync_a), .vsync_out(vsync_a),
    .hblnk_out(hblnk_a), .vblnk_out(vblnk_a),
    .frame_start(fs_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(BHA), .H_FP(BHF), .H_SYNC(BHS), .H_BP(BHB),
    .V_ACTIVE(BVA), .V_FP(BVF), .V_SYNC(BVS), .V_BP(BVB),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en),
    .hcount_out(hcount_b), .vcount_out(vcount_b),
    .hsync_out(hsync_b), .vsync_out(vsync_b),
    .hblnk_out(hblnk_b), .vblnk_out(vblnk_b),
    .frame_start(fs_b)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];  // expected frame_start spacing for instance B

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int pa = 0, pb = 0;  // pixel index within the frame
  bit fsa = 0, fsb = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pa = 0; pb = 0; fsa = 0; fsb = 0;
    end else if (en) begin
      pa = (pa + 1) % FRAME_A;
      pb = (pb + 1) % FRAME_B;
      fsa = (pa == 0);
      fsb = (pb == 0);
    end else begin
      fsa = 0; fsb = 0;
    end
  end

  function automatic void exp_out(input int p,
                                  input int ha, input int hf, input int hs, input int hb,
                                  input int va, input int vf, input int vs, input int vb,
                                  input bit hpol, input bit vpol,
                                  output int h, output int v,
                                  output bit hsync, output bit vsync,
                                  output bit hblnk, output bit vblnk);
    int ht;
    ht = ha + hf + hs + hb;
    h = p % ht;
    v = p / ht;
    hblnk = (h >= ha);
    vblnk = (v >= va);
    hsync = (h >= ha + hf && h < ha + hf + hs) ? hpol : !hpol;
    vsync = (v >= va + vf && v < va + vf + vs) ? vpol : !vpol;
  endfunction

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    int h, v;
    bit hs, vs, hb, vb;
    exp_out(pa, 1024, 24, 136, 160, 768, 3, 6, 29, 1'b0, 1'b0, h, v, hs, vs, hb, vb);
    check("a_hcount", int'(hcount_a), h);
    check("a_vcount", int'(vcount_a), v);
    check("a_hsync", int'(hsync_a), int'(hs));
    check("a_vsync", int'(vsync_a), int'(vs));
    check("a_hblnk", int'(hblnk_a), int'(hb));
    check("a_vblnk", int'(vblnk_a), int'(vb));
    check("a_frame_start", int'(fs_a), int'(fsa));
    exp_out(pb, BHA, BHF, BHS, BHB, BVA, BVF, BVS, BVB, 1'b1, 1'b1, h, v, hs, vs, hb, vb);
    check("b_hcount", int'(hcount_b), h);
    check("b_vcount", int'(vcount_b), v);
    check("b_hsync", int'(hsync_b), int'(hs));
    check("b_vsync", int'(vsync_b), int'(vs));
    check("b_hblnk", int'(hblnk_b), int'(hb));
    check("b_vblnk", int'(vblnk_b), int'(vb));
    check("b_frame_start", int'(fs_b), int'(fsb));
  end

  // ---------------- driver tasks ----------------
  task automatic wait_a_h(input int h);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (int'(hcount_a) != h && n < 3000);
    check("wait_a_hcount_timeout", int'(n < 3000), 1);
  endtask

  task automatic step_and_expect_a(input string name, input int h, input int v,
                                   input int hs, input int hb);
    @(negedge clk);
    check({name, "_h"}, int'(hcount_a), h);
    check({name, "_v"}, int'(vcount_a), v);
    check({name, "_hsync"}, int'(hsync_a), hs);
    check({name, "_hblnk"}, int'(hblnk_a), hb);
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_a_h"}, int'(hcount_a), 0);
    check({name, "_a_v"}, int'(vcount_a), 0);
    check({name, "_a_hsync"}, int'(hsync_a), 1);
    check({name, "_a_vsync"}, int'(vsync_a), 1);
    check({name, "_a_blnk"}, int'({hblnk_a, vblnk_a}), 0);
    check({name, "_a_fs"}, int'(fs_a), 0);
    check({name, "_b_h"}, int'(hcount_b), 0);
    check({name, "_b_sync"}, int'({hsync_b, vsync_b}), 0);
    check({name, "_b_fs"}, int'(fs_b), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int hold_v, n, prev_h, prev_v;
    repeat (3) @(negedge clk);
    en = 1'b1;
    rst_n = 1'b1;
    #1 check_reset_values("first_cycle");

    // One line of the XGA instance with hand-computed edge positions.
    wait_a_h(1023);
    check("h1023_hblnk", int'(hblnk_a), 0);
    step_and_expect_a("h1024", 1024, 0, 1, 1);
    wait_a_h(1047);
    check("h1047_hsync", int'(hsync_a), 1);
    step_and_expect_a("h1048", 1048, 0, 0, 1);
    wait_a_h(1183);
    check("h1183_hsync", int'(hsync_a), 0);
    step_and_expect_a("h1184", 1184, 0, 1, 1);
    wait_a_h(1343);
    check("h1343_v", int'(vcount_a), 0);
    step_and_expect_a("hwrap", 0, 1, 1, 0);
    check("hwrap_fs", int'(fs_a), 0);

    // Stall at hcount 500: everything frozen, then resume at 501.
    wait_a_h(500);
    hold_v = int'(vcount_a);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_h", int'(hcount_a), 500);
      check("stall_v", int'(vcount_a), hold_v);
      check("stall_fs", int'({fs_a, fs_b}), 0);
    end
    en = 1'b1;
    step_and_expect_a("resume", 501, hold_v, 1, 0);

    // Asynchronous reset mid-line, then recount from (0,0).
    wait_a_h(700);
    #2 rst_n = 1'b0;
    #1 check_reset_values("async_reset");
    @(negedge clk);
    check_reset_values("reset_held");
    rst_n = 1'b1;
    step_and_expect_a("after_reset", 1, 0, 1, 0);

    // Randomised enable over several small-raster frames.
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      en = ($urandom_range(0, 7) != 0);
    end
    @(negedge clk);
    en = 1'b1;

    // Frame pulse spacing on the small raster with en held high.
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (fs_b !== 1'b1 && n < 400);
    check("b_first_pulse_timeout", int'(n < 400), 1);
    check("b_pulse_h", int'(hcount_b), 0);
    check("b_pulse_v", int'(vcount_b), 0);
    exp_q.push_back(32'(FRAME_B));
    n = 0;
    prev_h = 0;
    prev_v = 0;
    do begin
      prev_h = int'(hcount_b);
      prev_v = int'(vcount_b);
      @(negedge clk);
      n++;
    end while (fs_b !== 1'b1 && n < 400);
    check("b_last_pixel_h", prev_h, 15);
    check("b_last_pixel_v", prev_v, 9);
    if (exp_q.size() > 0) check("b_pulse_spacing", n, int'(exp_q.pop_front()));
    @(negedge clk);
    check("b_pulse_one_cycle", int'(fs_b), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #5ms;
    errors++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
